word_loader: RTL

WORD_LOADER -- requirements
Module: word_loader

---
 rtl/word_loader_pkg.sv | 32 +++
 rtl/word_loader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/word_loader_pkg.sv
// word_loader_pkg
//   Shared definitions for the word loader: FSM state encoding, the
//   big-endian byte offsets within a 16-bit word, and a byte address helper.
//   Optional feature macro (consumed by word_loader): WORD_LOADER_TIMEOUT_EN.
package word_loader_pkg;

    typedef enum logic [2:0] {
        WL_IDLE     = 3'd0,
        WL_FETCH_HI = 3'd1,
        WL_WRITE_HI = 3'd2,
        WL_FETCH_LO = 3'd3,
        WL_WRITE_LO = 3'd4
    } wl_state_e;

    // Plain vector constants so the FSM register can stay a logic vector.
    localparam logic [2:0] ST_IDLE     = WL_IDLE;
    localparam logic [2:0] ST_FETCH_HI = WL_FETCH_HI;
    localparam logic [2:0] ST_WRITE_HI = WL_WRITE_HI;
    localparam logic [2:0] ST_FETCH_LO = WL_FETCH_LO;
    localparam logic [2:0] ST_WRITE_LO = WL_WRITE_LO;

    // Big-endian: upper byte at the base address, lower byte right after.
    localparam logic [15:0] BYTE_HI_OFFSET = 16'd0;
    localparam logic [15:0] BYTE_LO_OFFSET = 16'd1;

    // 16-bit address arithmetic; 0xFFFF + 1 wraps to 0x0000.
    function automatic logic [15:0] byte_addr(input logic [15:0] base,
                                              input logic [15:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/word_loader.sv
// word_loader
//   Fetches a big-endian 16-bit word from a byte-wide memory (two handshaked
//   byte reads) and writes it into a register file, upper byte strobe first,
//   then lower byte strobe.
//
//   Optional feature: define WORD_LOADER_TIMEOUT_EN to abort a byte fetch
//   after TIMEOUT_CYCLES cycles without mem_ack (err pulse, back to IDLE).
//   Without the macro err is tied low and a fetch waits indefinitely.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     start                 load request (honoured in IDLE only)
//     mem_addr, dest_addr   word byte address / destination register index
//     mem_req, mem_raddr    byte read request and its address
//     mem_rdata, mem_ack    returned byte and its accept/valid flag
//     reg3_writeu/writel    upper/lower byte write strobes
//     reg3_addr, reg3_bus   register index and write data
//     busy, done, err       status: not idle / completion pulse / abort pulse
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   IDLE     | waiting for start
//   FETCH_HI | requesting upper byte at base address
//   WRITE_HI | one-cycle upper byte write strobe
//   FETCH_LO | requesting lower byte at base address + 1
//   WRITE_LO | one-cycle lower byte write strobe, done pulse
module word_loader
    import word_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mem_addr,
    input  logic [3:0]  dest_addr,
    output logic        mem_req,
    output logic [15:0] mem_raddr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        reg3_writeu,
    output logic        reg3_writel,
    output logic [3:0]  reg3_addr,
    output logic [15:0] reg3_bus,
    output logic        busy,
    output logic        done,
    output logic        err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("word_loader: TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]  state;
    logic [15:0] base_addr;

`ifdef WORD_LOADER_TIMEOUT_EN
    // Down-counter reloaded on each FETCH entry; expiry at terminal count 0.
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            base_addr <= '0;
            mem_raddr <= '0;
            reg3_addr <= '0;
            reg3_bus  <= '0;
`ifdef WORD_LOADER_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef WORD_LOADER_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_addr <= mem_addr;
                        mem_raddr <= byte_addr(mem_addr, BYTE_HI_OFFSET);
                        reg3_addr <= dest_addr;
                        state     <= ST_FETCH_HI;
`ifdef WORD_LOADER_TIMEOUT_EN
                        to_cnt    <= TO_LOAD;
`endif
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ack) begin
                        reg3_bus[15:8] <= mem_rdata;
                        state          <= ST_WRITE_HI;
                    end
`ifdef WORD_LOADER_TIMEOUT_EN
                    else if (to_cnt == 16'd0) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt - 16'd1;
                    end
`endif
                end
                ST_WRITE_HI: begin
                    mem_raddr <= byte_addr(base_addr, BYTE_LO_OFFSET);
                    state     <= ST_FETCH_LO;
`ifdef WORD_LOADER_TIMEOUT_EN
                    to_cnt    <= TO_LOAD;
`endif
                end
                ST_FETCH_LO: begin
                    if (mem_ack) begin
                        reg3_bus[7:0] <= mem_rdata;
                        state         <= ST_WRITE_LO;
                    end
`ifdef WORD_LOADER_TIMEOUT_EN
                    else if (to_cnt == 16'd0) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt - 16'd1;
                    end
`endif
                end
                ST_WRITE_LO: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode directly from state, so they can never overlap.
    assign busy        = (state != ST_IDLE);
    assign mem_req     = (state == ST_FETCH_HI) || (state == ST_FETCH_LO);
    assign reg3_writeu = (state == ST_WRITE_HI);
    assign reg3_writel = (state == ST_WRITE_LO);
    assign done        = (state == ST_WRITE_LO);

endmodule
